onchip_mem_arbiter_2p: RTL and testbench
========================================

// Module: onchip_mem_arbiter_2p
// PURPOSE
//   Shares the single-port 64-bit on-chip RAM (16384 words, 1-cycle read latency) between two
//   Avalon-MM masters: m0 = HPS/lightweight bridge, m1 = zoom coprocessor pixel engine.
//   Round-robin arbitration, one access per cycle; read data is returned in request order,
//   tagged to the issuing master.
// PARAMETERS
//   ADDR_W  14  word address width (16384 x 64-bit words)
//   DATA_W  64  data width
//   BE_W     8  byte-enable width (DATA_W/8)
//   RD_LAT   1  RAM read latency in cycles (address to readdata); legal range 1..4
// PORTS
//   clk               in   1       system clock
//   reset             in   1       synchronous, active-high reset
//   mN_address        in   ADDR_W  master N word address (N = 0,1)
//   mN_byteenable     in   BE_W    master N byte enables (writes only)
//   mN_read           in   1       master N read request
//   mN_write          in   1       master N write request
//   mN_writedata      in   DATA_W  master N write data
//   mN_waitrequest    out  1       1 = request not accepted this cycle
//   mN_readdata       out  DATA_W  read data (broadcast from RAM; qualify with readdatavalid)
//   mN_readdatavalid  out  1       mN_readdata is valid for master N this cycle
//   mem_address       out  ADDR_W  to RAM address
//   mem_byteenable    out  BE_W    to RAM byteenable; all-ones on reads
//   mem_chipselect    out  1       to RAM chipselect
//   mem_write         out  1       to RAM write
//   mem_writedata     out  DATA_W  to RAM writedata
//   mem_clken         out  1       to RAM clken; tied 1
//   mem_readdata      in   DATA_W  from RAM readdata
// BEHAVIOUR
//   - reqN = mN_read | mN_write. A request is accepted in a cycle where reqN=1 and
//     mN_waitrequest=0. Masters hold all request signals stable until accepted.
//   - Priority pointer `last` (1 bit, registered) = index of the last master granted.
//     - Only one master requesting: that master is granted.
//     - Both requesting: grant goes to the master != last.
//     - No request: no grant; `last` holds.
//   - Grant is combinational from req and `last`:
//     - Granted master: waitrequest=0.
//     - Other master: waitrequest=1 if it is requesting, else 0 (don't-care).
//     - mem_* are driven combinationally from the granted master.
//     - mem_chipselect = 1 only on a grant; mem_write = 1 only on a granted write.
//   - mN_read and mN_write both asserted: treated as a write; no readdatavalid is generated.
//   - Read return uses a tag shift register, RD_LAT stages of {valid, id}:
//     - Stage 0 is loaded on each granted read.
//     - mN_readdatavalid = last stage valid && id == N.
//     - Latency from accept to readdatavalid = RD_LAT cycles exactly (1 with default).
//   - Back-to-back grants are allowed every cycle; throughput is 1 access/cycle total.
//   - Order: accesses take effect at the RAM in grant order. A read granted after a write to
//     the same address returns the new data. Same-cycle hazards cannot occur (single grant).
//   - Reset (synchronous) — state:
//     - `last` <= 1, so m0 wins the first contention after reset.
//     - Tag pipeline cleared; in-flight reads are dropped and no readdatavalid follows.
//   - Reset (synchronous) — outputs while reset=1:
//     - both waitrequest = 1; mem_chipselect = 0; mem_write = 0.
//     - readdatavalid = 0; mem_clken = 1.
//   - Post-reset output values: readdatavalid=0, waitrequest=0 (no request), mem_chipselect=0.
// TESTING
//   1. m0 read addr 0x0010 alone -> accepted cycle 0; m0_readdatavalid=1 cycle 1 with RAM
//      word 0x10; m1_readdatavalid stays 0.
//   2. m0 and m1 both read continuously for 8 cycles after reset -> grants alternate
//      m0,m1,m0,...; each gets 4 accepts and 4 readdatavalids, each 1 cycle after its accept.
//   3. m1 write 0x0123_4567_89AB_CDEF to addr 0x3FFF, be=0x0F, then m0 read 0x3FFF next cycle
//      -> low 32 bits = 0x89ABCDEF, high 32 bits unchanged.
//   4. m0 read and m1 write contend while last=0 -> m1 granted, m0 waitrequest=1;
//      m0 granted next cycle.
//   5. reset asserted one cycle after a granted read -> no readdatavalid emitted; both
//      waitrequest=1 during reset; m0 wins the first contention afterward.
//   6. m0 asserts read+write together -> write performed, no readdatavalid.

Source files
------------

// File: rtl/onchip_mem_arbiter_2p.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM.
// Read data returns in grant order, tagged to the issuing master through a RD_LAT-deep tag pipe.
module onchip_mem_arbiter_2p #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64,
  parameter int BE_W   = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic              req0_s;
  logic              req1_s;
  logic              gnt0_s;
  logic              gnt1_s;
  logic              gnt_any_s;
  logic              sel_wr_s;
  logic              gnt_rd_s;
  logic              last_r;
  logic [RD_LAT-1:0] tag_vld_r;
  logic [RD_LAT-1:0] tag_id_r;
  logic [RD_LAT:0]   vld_shift_s;
  logic [RD_LAT:0]   id_shift_s;

  // Grant selection: a lone requester wins, contention goes to the master not granted last.
  always_comb begin
    req0_s = m0_read | m0_write;
    req1_s = m1_read | m1_write;
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (reset) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0_s && req1_s) begin
      gnt0_s = last_r;
      gnt1_s = ~last_r;
    end else begin
      gnt0_s = req0_s;
      gnt1_s = req1_s;
    end
    gnt_any_s = gnt0_s | gnt1_s;
  end

  // RAM-side mux from the granted master; read+write together counts as a write.
  always_comb begin
    mem_address    = m0_address;
    mem_writedata  = m0_writedata;
    mem_byteenable = {BE_W{1'b1}};
    sel_wr_s       = 1'b0;
    if (gnt1_s) begin
      mem_address    = m1_address;
      mem_writedata  = m1_writedata;
      sel_wr_s       = m1_write;
      mem_byteenable = m1_write ? m1_byteenable : {BE_W{1'b1}};
    end else begin
      mem_address    = m0_address;
      mem_writedata  = m0_writedata;
      sel_wr_s       = m0_write;
      mem_byteenable = m0_write ? m0_byteenable : {BE_W{1'b1}};
    end
    mem_chipselect = gnt_any_s;
    mem_write      = gnt_any_s & sel_wr_s;
    gnt_rd_s       = gnt_any_s & ~sel_wr_s;
    mem_clken      = 1'b1;
  end

  // Master handshake and tagged read-return qualifiers.
  always_comb begin
    m0_waitrequest   = 1'b1;
    m1_waitrequest   = 1'b1;
    m0_readdatavalid = 1'b0;
    m1_readdatavalid = 1'b0;
    if (reset) begin
      m0_waitrequest   = 1'b1;
      m1_waitrequest   = 1'b1;
      m0_readdatavalid = 1'b0;
      m1_readdatavalid = 1'b0;
    end else begin
      m0_waitrequest   = req0_s & ~gnt0_s;
      m1_waitrequest   = req1_s & ~gnt1_s;
      m0_readdatavalid = tag_vld_r[RD_LAT-1] & ~tag_id_r[RD_LAT-1];
      m1_readdatavalid = tag_vld_r[RD_LAT-1] & tag_id_r[RD_LAT-1];
    end
    m0_readdata = mem_readdata;
    m1_readdata = mem_readdata;
  end

  // Next tag-pipe contents: new read tag enters stage 0, everything moves one stage.
  always_comb begin
    vld_shift_s = {tag_vld_r, gnt_rd_s};
    id_shift_s  = {tag_id_r, gnt1_s};
  end

  // Round-robin pointer and read tag pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_r    <= 1'b1;
      tag_vld_r <= '0;
      tag_id_r  <= '0;
    end else begin
      if (gnt_any_s) begin
        last_r <= gnt1_s;
      end else begin
        last_r <= last_r;
      end
      tag_vld_r <= vld_shift_s[RD_LAT-1:0];
      tag_id_r  <= id_shift_s[RD_LAT-1:0];
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter_2p.sv
// Directed bench for onchip_mem_arbiter_2p with a behavioural 1-cycle RAM and a
// scoreboard that matches every readdatavalid against hand-computed expectations.
module tb_onchip_mem_arbiter_2p;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] m0_address, m1_address;
  logic [7:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [63:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [63:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [13:0] mem_address;
  logic [7:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [63:0] mem_writedata, mem_readdata;

  typedef struct {
    logic        id;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          compared = 0;
  int          failed = 0;
  int          cyc = 0;
  logic [63:0] ram [16384];

  onchip_mem_arbiter_2p dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input logic [13:0] a);
    return {16'hDA7A, 2'b00, a, 16'hBEEF, 2'b00, a};
  endfunction

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = pat(14'(i));
  end

  // Behavioural single-port RAM, one cycle read latency.
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 8; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every readdatavalid must match the oldest expected response.
  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] rd;
    if (m0_readdatavalid && m1_readdatavalid) begin
      compared++; failed++;
      $display("FAIL rdv_both: both readdatavalid high at cycle %0d", cyc);
    end else if (m0_readdatavalid || m1_readdatavalid) begin
      compared++;
      rd = m1_readdatavalid ? m1_readdata : m0_readdata;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL rdv_unexpected: m%0d data=%h at cycle %0d, required none",
                 m1_readdatavalid, rd, cyc);
      end else begin
        e = sb.pop_front();
        if (e.id != m1_readdatavalid || e.data != rd || e.cyc != cyc) begin
          failed++;
          $display("FAIL rdv_match: got m%0d data=%h cyc=%0d, required m%0d data=%h cyc=%0d",
                   m1_readdatavalid, rd, cyc, e.id, e.data, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus: drive, check handshake at negedge, queue expected read returns.
  task automatic step(input logic rst,
                      input logic r0, input logic w0, input logic [13:0] a0,
                      input logic [7:0] be0, input logic [63:0] d0,
                      input logic r1, input logic w1, input logic [13:0] a1,
                      input logic [7:0] be1, input logic [63:0] d1,
                      input logic ew0, input logic ew1, input logic ecs, input logic emw,
                      input logic p0, input logic [63:0] e0,
                      input logic p1, input logic [63:0] e1);
    reset = rst;
    m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
    @(negedge clk);
    chk("m0_waitrequest", 64'(m0_waitrequest), 64'(ew0));
    chk("m1_waitrequest", 64'(m1_waitrequest), 64'(ew1));
    chk("mem_chipselect", 64'(mem_chipselect), 64'(ecs));
    chk("mem_write", 64'(mem_write), 64'(emw));
    chk("mem_clken", 64'(mem_clken), 64'd1);
    if (ecs && !emw) chk("mem_byteenable_rd", 64'(mem_byteenable), 64'hFF);
    if (p0) sb.push_back('{id: 1'b0, data: e0, cyc: cyc + 1});
    if (p1) sb.push_back('{id: 1'b1, data: e1, cyc: cyc + 1});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      step(1'b0, 1'b0, 1'b0, 14'h0, 8'h0, 64'h0, 1'b0, 1'b0, 14'h0, 8'h0, 64'h0,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
  endtask

  initial begin
    logic [63:0] w3;
    reset = 1'b1;
    m0_read = 1'b0; m0_write = 1'b0; m0_address = 14'h0; m0_byteenable = 8'h0; m0_writedata = 64'h0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = 14'h0; m1_byteenable = 8'h0; m1_writedata = 64'h0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++)
      step(1'b1, 1'b0, 1'b0, 14'h0, 8'h0, 64'h0, 1'b0, 1'b0, 14'h0, 8'h0, 64'h0,
           1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    idle(1);

    // Lone m0 read of 0x0010.
    step(1'b0, 1'b1, 1'b0, 14'h0010, 8'h0, 64'h0, 1'b0, 1'b0, 14'h0, 8'h0, 64'h0,
         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, pat(14'h0010), 1'b0, 64'h0);
    idle(2);

    // Reset, then both masters read continuously: m0 first, then alternate.
    step(1'b1, 1'b1, 1'b0, 14'h0020, 8'h0, 64'h0, 1'b1, 1'b0, 14'h0040, 8'h0, 64'h0,
         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 1'b0, 14'(14'h20 + (i + 1) / 2), 8'h0, 64'h0,
           1'b1, 1'b0, 14'(14'h40 + i / 2), 8'h0, 64'h0,
           1'(i % 2), 1'(1 - i % 2), 1'b1, 1'b0,
           1'(1 - i % 2), pat(14'(14'h20 + (i + 1) / 2)),
           1'(i % 2), pat(14'(14'h40 + i / 2)));
    idle(2);

    // m1 partial write to 0x3FFF, then m0 reads it back.
    step(1'b0, 1'b0, 1'b0, 14'h0, 8'h0, 64'h0, 1'b0, 1'b1, 14'h3FFF, 8'h0F, 64'h0123_4567_89AB_CDEF,
         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
    w3 = pat(14'h3FFF);
    step(1'b0, 1'b1, 1'b0, 14'h3FFF, 8'h0, 64'h0, 1'b0, 1'b0, 14'h0, 8'h0, 64'h0,
         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, {w3[63:32], 32'h89AB_CDEF}, 1'b0, 64'h0);
    idle(2);

    // Contention with last=0: m1 write wins, m0 read follows.
    step(1'b0, 1'b1, 1'b0, 14'h0030, 8'h0, 64'h0, 1'b0, 1'b1, 14'h0031, 8'hFF, 64'h1111_2222_3333_4444,
         1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
    step(1'b0, 1'b1, 1'b0, 14'h0030, 8'h0, 64'h0, 1'b0, 1'b0, 14'h0, 8'h0, 64'h0,
         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, pat(14'h0030), 1'b0, 64'h0);
    idle(2);

    // Reset right after a granted read drops it; m0 wins first contention afterwards.
    step(1'b0, 1'b1, 1'b0, 14'h0050, 8'h0, 64'h0, 1'b0, 1'b0, 14'h0, 8'h0, 64'h0,
         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    for (int k = 0; k < 2; k++)
      step(1'b1, 1'b1, 1'b0, 14'h0051, 8'h0, 64'h0, 1'b1, 1'b0, 14'h0052, 8'h0, 64'h0,
           1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    step(1'b0, 1'b1, 1'b0, 14'h0051, 8'h0, 64'h0, 1'b1, 1'b0, 14'h0052, 8'h0, 64'h0,
         1'b0, 1'b1, 1'b1, 1'b0, 1'b1, pat(14'h0051), 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 14'h0, 8'h0, 64'h0, 1'b1, 1'b0, 14'h0052, 8'h0, 64'h0,
         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1, pat(14'h0052));
    idle(2);

    // Read+write together acts as a write with no read return.
    step(1'b0, 1'b1, 1'b1, 14'h0005, 8'hFF, 64'hFEED_FACE_CAFE_BEEF, 1'b0, 1'b0, 14'h0, 8'h0, 64'h0,
         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
    step(1'b0, 1'b1, 1'b0, 14'h0005, 8'h0, 64'h0, 1'b0, 1'b0, 14'h0, 8'h0, 64'h0,
         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'hFEED_FACE_CAFE_BEEF, 1'b0, 64'h0);
    idle(3);

    compared++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
